pvr_vram_arb: RTL and testbench
===============================

// Module: pvr_vram_arb
// PURPOSE
//  Round-robin read/write arbiter sharing the single PVR VRAM port between render-side masters:
//  region-array/OL parser (req 0), ISP polygon-parameter fetch (req 1), texture fetch (req 2).
//  Grants one access per cycle, drives the VRAM port and routes read data back by tag pipe.
//  Sits between the render front-end masters and the VRAM controller.
// PARAMETERS
//  N_REQ      3   number of requesters (index 0..N_REQ-1)
//  AW         24  VRAM byte address width (full 16MB)
//  DW         32  data width
//  RD_LAT     1   cycles from vram_rd high to vram_din valid (>=1)
//  MAX_BURST  8   max consecutive locked grants to one requester (lock feature only)
// PORTS
//  clock       in   1          system clock
//  reset       in   1          synchronous, active-high reset
//  req         in   N_REQ      access request, held until ack
//  req_wr      in   N_REQ      1=write, 0=read, qualified by req
//  req_addr    in   N_REQ*AW   address, slice i = [i*AW +: AW]
//  req_wdata   in   N_REQ*DW   write data, slice i = [i*DW +: DW]
//  lock        in   N_REQ      burst lock hint (used only with PVR_ARB_LOCK_EN)
//  ack         out  N_REQ      combinational grant, one-hot or zero; access accepted this cycle
//  rvalid      out  N_REQ      read data valid for requester i, one-hot or zero
//  rdata       out  DW         read data (= vram_din), shared by all requesters
//  vram_busy   in   1          VRAM controller stall; no grant while high
//  vram_rd     out  1          registered read strobe
//  vram_wr     out  1          registered write strobe
//  vram_addr   out  AW         registered address
//  vram_wdata  out  DW         registered write data
//  vram_din    in   DW         read data, valid RD_LAT cycles after vram_rd
// BEHAVIOUR
//  - Reset: vram_rd=0, vram_wr=0, vram_addr=0, vram_wdata=0, tag pipe cleared (rvalid=0),
//    rr_last=N_REQ-1 (requester 0 wins first), burst_cnt=0. ack is combinational, so it is 0 while reset is high.
//  - Arbitration in cycle t: if !vram_busy and |req, the winner is the first requester with req set,
//    searching from rr_last+1 and wrapping modulo N_REQ. ack[winner]=1 in cycle t. Requester
//    updates req/addr at the t edge; back-to-back acks to one requester are legal.
//  - Edge end of t: vram_addr/vram_wdata <= winner slices, vram_rd <= !req_wr[w], vram_wr <= req_wr[w],
//    rr_last <= w. No winner: vram_rd=vram_wr=0, addr/wdata hold.
//  - Read return: tag {valid,idx} enters a RD_LAT-deep shift pipe with vram_rd; tag pipe shifts every
//    cycle regardless of vram_busy. rvalid[idx]=1 and rdata=vram_din in cycle t+1+RD_LAT. Writes
//    produce no rvalid.
//  - Throughput: 1 access/cycle total; in-order returns; no per-requester outstanding limit.
//  - vram_busy high: ack=0, no new strobe, rr_last and burst_cnt hold, in-flight reads still return.
//  - Single requester: granted every cycle. All requesting continuously: grant order 0,1,2,0,1,2...
//  - req dropped before ack: no access issued, no state change.
//  - Reset mid-operation: in-flight reads are discarded (no rvalid after reset), arbiter restarts at req 0.
// CONFIGURATION
//  PVR_ARB_LOCK_EN defined: if rr_last has req=1 and lock=1 and burst_cnt<MAX_BURST-1, it wins again
//    and burst_cnt increments. Otherwise normal round-robin applies and burst_cnt<=0.
//    Any grant to a different requester also clears burst_cnt. This serves sequential RA entry reads.
//  PVR_ARB_LOCK_EN undefined: lock is ignored and there is no burst_cnt; pure round-robin.
// TESTING
//  1. Reset, req=001, addr0=0x000100, read, RD_LAT=1 -> ack=001 same cycle; vram_rd=1, addr=0x000100
//     next cycle; rvalid=001, rdata=vram_din one cycle later.
//  2. req=111 held 6 cycles, all reads -> ack sequence 001,010,100,001,010,100; rvalid tags match 2 cycles later.
//  3. req=010 write, addr1=0x200000, wdata1=0xDEADBEEF -> vram_wr=1, vram_addr=0x200000,
//     vram_wdata=0xDEADBEEF; no rvalid.
//  4. vram_busy=1 for 3 cycles with req=011 and one read in flight -> ack=0, vram_rd=0, in-flight
//     rvalid still appears. After busy drops, req 0 is granted first (rr_last unchanged).
//  5. Reset asserted the cycle after vram_rd, RD_LAT=3 -> rvalid stays 0. After release, req=100 is acked immediately.
//  6. PVR_ARB_LOCK_EN, MAX_BURST=8, req=111, lock=001 -> req 0 gets 8 consecutive acks, then 010.
//     Without the macro -> 001,010,100 rotation.

Source files
------------

// File: rtl/pvr_vram_arb.sv
// pvr_vram_arb -- round-robin arbiter sharing the single PVR VRAM port between the
// render-side masters: RA/OL parser (req 0), ISP parameter fetch (req 1) and texture
// fetch (req 2). One access is granted per cycle. The VRAM strobes are registered, and
// read data is routed back to its requester through a tag pipe.
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   req/req_wr/lock         per-requester request, write flag, burst lock hint
//   req_addr/req_wdata      packed per-requester address and write data slices
//   ack                     combinational grant (one-hot or zero)
//   rvalid/rdata            read return (one-hot valid, shared data = vram_din)
//   vram_busy               controller stall; no grant while high
//   vram_rd/vram_wr         registered strobes to the VRAM controller
//   vram_addr/vram_wdata    registered address / write data
//   vram_din                read data, valid RD_LAT cycles after vram_rd
//
// Build option: define PVR_ARB_LOCK_EN to let a locked requester keep the port for up
// to MAX_BURST consecutive grants. Without it, lock is ignored and arbitration is pure
// round-robin.
module pvr_vram_arb #(
  parameter int N_REQ     = 3,
  parameter int AW        = 24,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_wr,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*DW-1:0]   req_wdata,
  input  logic [N_REQ-1:0]      lock,
  output logic [N_REQ-1:0]      ack,
  output logic [N_REQ-1:0]      rvalid,
  output logic [DW-1:0]         rdata,
  input  logic                  vram_busy,
  output logic                  vram_rd,
  output logic                  vram_wr,
  output logic [AW-1:0]         vram_addr,
  output logic [DW-1:0]         vram_wdata,
  input  logic [DW-1:0]         vram_din
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0]             rr_last_q, rr_last_d;
  logic                      vram_rd_q, vram_rd_d;
  logic                      vram_wr_q, vram_wr_d;
  logic [AW-1:0]             vram_addr_q, vram_addr_d;
  logic [DW-1:0]             vram_wdata_q, vram_wdata_d;
  logic [IW-1:0]             vram_idx_q, vram_idx_d;
  logic [RD_LAT-1:0]         tag_v_q, tag_v_d;
  logic [RD_LAT-1:0][IW-1:0] tag_idx_q, tag_idx_d;

  logic          rr_found_s;
  logic [IW-1:0] rr_win_s;
  logic [IW-1:0] cand_s;
  int            cand_i;
  logic [IW-1:0] sel_s;
  logic          grant_s;

  // Round-robin search: first requester after rr_last, wrapping modulo N_REQ.
  always_comb begin
    rr_found_s = 1'b0;
    rr_win_s   = '0;
    cand_i     = 0;
    cand_s     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_i = int'(rr_last_q) + k;
      if (cand_i >= N_REQ) begin
        cand_i = cand_i - N_REQ;
      end else begin
        cand_i = cand_i;
      end
      cand_s = IW'(cand_i);
      if (!rr_found_s && req[cand_s]) begin
        rr_found_s = 1'b1;
        rr_win_s   = cand_s;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

`ifdef PVR_ARB_LOCK_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          lock_hit_s;

  // Burst lock: the last winner keeps the port while it requests with lock set and
  // the burst budget is not exhausted; every other grant (or an idle cycle) restarts it.
  always_comb begin
    lock_hit_s = req[rr_last_q] && lock[rr_last_q] &&
                 (burst_cnt_q < BW'(MAX_BURST - 1));
    if (vram_busy) begin
      sel_s       = rr_win_s;
      burst_cnt_d = burst_cnt_q;
    end else if (lock_hit_s) begin
      sel_s       = rr_last_q;
      burst_cnt_d = burst_cnt_q + BW'(1);
    end else begin
      sel_s       = rr_win_s;
      burst_cnt_d = '0;
    end
    grant_s = !reset && !vram_busy && rr_found_s;
  end

  // Burst counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  logic lock_unused_s;

  // Pure round-robin; the lock hint has no effect in this build.
  always_comb begin
    lock_unused_s = ^lock;
    sel_s         = rr_win_s;
    grant_s       = !reset && !vram_busy && rr_found_s;
  end
`endif

  // Grant decode and next-state for the VRAM port registers and tag pipe.
  always_comb begin
    ack          = '0;
    rr_last_d    = rr_last_q;
    vram_rd_d    = 1'b0;
    vram_wr_d    = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_wdata_d = vram_wdata_q;
    vram_idx_d   = vram_idx_q;
    if (grant_s) begin
      ack[sel_s]   = 1'b1;
      rr_last_d    = sel_s;
      vram_rd_d    = !req_wr[sel_s];
      vram_wr_d    = req_wr[sel_s];
      vram_addr_d  = req_addr[int'(sel_s)*AW +: AW];
      vram_wdata_d = req_wdata[int'(sel_s)*DW +: DW];
      vram_idx_d   = sel_s;
    end else begin
      ack = '0;
    end
    // Tag enters alongside the registered read strobe and shifts every cycle,
    // so stage RD_LAT-1 lines up with vram_din.
    tag_v_d      = tag_v_q;
    tag_idx_d    = tag_idx_q;
    tag_v_d[0]   = vram_rd_q;
    tag_idx_d[0] = vram_idx_q;
    for (int k = 1; k < RD_LAT; k++) begin
      tag_v_d[k]   = tag_v_q[k-1];
      tag_idx_d[k] = tag_idx_q[k-1];
    end
  end

  // Port, arbitration and tag pipe registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_last_q    <= IW'(N_REQ - 1);
      vram_rd_q    <= 1'b0;
      vram_wr_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_wdata_q <= '0;
      vram_idx_q   <= '0;
      tag_v_q      <= '0;
      tag_idx_q    <= '0;
    end else begin
      rr_last_q    <= rr_last_d;
      vram_rd_q    <= vram_rd_d;
      vram_wr_q    <= vram_wr_d;
      vram_addr_q  <= vram_addr_d;
      vram_wdata_q <= vram_wdata_d;
      vram_idx_q   <= vram_idx_d;
      tag_v_q      <= tag_v_d;
      tag_idx_q    <= tag_idx_d;
    end
  end

  // Read return decode from the last tag stage.
  always_comb begin
    rvalid = '0;
    if (tag_v_q[RD_LAT-1]) begin
      rvalid[tag_idx_q[RD_LAT-1]] = 1'b1;
    end else begin
      rvalid = '0;
    end
  end

  assign rdata      = vram_din;
  assign vram_rd    = vram_rd_q;
  assign vram_wr    = vram_wr_q;
  assign vram_addr  = vram_addr_q;
  assign vram_wdata = vram_wdata_q;

endmodule

// File: tb/tb_pvr_vram_arb.sv
// Testbench for pvr_vram_arb. Two instances share all stimulus: one with RD_LAT=1 and
// one with RD_LAT=3. A table of per-cycle vectors carries the inputs and the expected
// ack. Expected VRAM strobes and read returns are pushed to scoreboard queues when a
// vector is driven, and they are popped when the DUT should produce them.
module tb_pvr_vram_arb;

  localparam int N = 3;
  localparam int AW = 24;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req, req_wr, lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic          vram_busy;
  logic [DW-1:0] vram_din;

  logic [N-1:0]  ack1, rvalid1, ack3, rvalid3;
  logic [DW-1:0] rdata1, rdata3, wdata1, wdata3;
  logic          rd1, wr1, rd3, wr3;
  logic [AW-1:0] addr1, addr3;

  pvr_vram_arb #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(1), .MAX_BURST(8)) dut1 (
    .clock(clock), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .lock(lock), .ack(ack1), .rvalid(rvalid1), .rdata(rdata1),
    .vram_busy(vram_busy), .vram_rd(rd1), .vram_wr(wr1), .vram_addr(addr1),
    .vram_wdata(wdata1), .vram_din(vram_din));

  pvr_vram_arb #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(3), .MAX_BURST(8)) dut3 (
    .clock(clock), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .lock(lock), .ack(ack3), .rvalid(rvalid3), .rdata(rdata3),
    .vram_busy(vram_busy), .vram_rd(rd3), .vram_wr(wr3), .vram_addr(addr3),
    .vram_wdata(wdata3), .vram_din(vram_din));

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [2:0]  lock;
    logic        busy;
    logic        rst;
    logic [23:0] a;
    logic [31:0] d;
    logic [2:0]  exp_ack;
  } vec_t;

  typedef struct {
    int due;
    int idx;
  } rd_t;

  vec_t        vecs[$];
  logic [57:0] sb_st[$];
  rd_t         rdq1[$];
  rd_t         rdq3[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic add(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                     input logic b, input logic rs, input logic [23:0] a,
                     input logic [31:0] d, input logic [2:0] e);
    vec_t v;
    v.req = r; v.wr = w; v.lock = l; v.busy = b; v.rst = rs;
    v.a = a; v.d = d; v.exp_ack = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic chk_rd(input string nm, input logic [2:0] rv, input logic [31:0] rd,
                        input logic [2:0] exp_rv, input logic [31:0] din);
    chk({nm, "_rvalid"}, 64'(rv), 64'(exp_rv));
    if (exp_rv != 3'b000) begin
      chk({nm, "_rdata"}, 64'(rd), 64'(din));
    end
  endtask

  initial begin
    vec_t        v;
    logic        armed;
    logic [23:0] last_a;
    logic [31:0] last_d;
    logic [2:0]  erv;
    logic [31:0] din;
    int          w;
    rd_t         e;

    armed = 1'b0;
    last_a = '0;
    last_d = '0;
    reset = 1'b1; req = '0; req_wr = '0; lock = '0; vram_busy = 1'b0;
    req_addr = '0; req_wdata = '0; vram_din = '0;

    // Reset with all requesting: ack must stay low.
    add(3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 24'h000000, 32'h0, 3'b000);
    add(3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 24'h000000, 32'h0, 3'b000);
    // Single read from req 0, then idle while it returns.
    add(3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 24'h000100, 32'h11110000, 3'b001);
    add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 24'h000200, 32'h0, 3'b000);
    add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 24'h000300, 32'h0, 3'b000);
    // Move rr_last to 2, then all three request reads for 6 cycles.
    add(3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 24'h000400, 32'h0, 3'b100);
    for (int i = 0; i < 6; i++) begin
      add(3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 24'h001000 + 24'(i * 16), 32'h0,
          3'b001 << (i % 3));
    end
    for (int i = 0; i < 3; i++) add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 24'h0, 32'h0, 3'b000);
    // Write from req 1 to 0x200000 / 0xDEADBEEF.
    add(3'b010, 3'b010, 3'b000, 1'b0, 1'b0, 24'h100000, 32'hDEADBEEE, 3'b010);
    add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 24'h0, 32'h0, 3'b000);
    // Read from req 2 in flight, then 3 busy cycles with req 0 and 1 waiting.
    add(3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 24'h002000, 32'h0, 3'b100);
    for (int i = 0; i < 3; i++) add(3'b011, 3'b000, 3'b000, 1'b1, 1'b0, 24'h003000, 32'h0, 3'b000);
    add(3'b011, 3'b000, 3'b000, 1'b0, 1'b0, 24'h004000, 32'h0, 3'b001);
    add(3'b011, 3'b000, 3'b000, 1'b0, 1'b0, 24'h005000, 32'h0, 3'b010);
    for (int i = 0; i < 3; i++) add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 24'h0, 32'h0, 3'b000);
    // Mixed reads/writes and a busy cycle with nothing requesting.
    add(3'b101, 3'b001, 3'b000, 1'b0, 1'b0, 24'h006000, 32'h22220000, 3'b100);
    add(3'b101, 3'b001, 3'b000, 1'b0, 1'b0, 24'h007000, 32'h33330000, 3'b001);
    add(3'b110, 3'b110, 3'b000, 1'b0, 1'b0, 24'h008000, 32'h44440000, 3'b010);
    add(3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 24'h0, 32'h0, 3'b000);
    for (int i = 0; i < 3; i++) add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 24'h0, 32'h0, 3'b000);
    // Read, then reset the cycle after vram_rd: the read must never return.
    add(3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 24'h009000, 32'h0, 3'b100);
    add(3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 24'h00A000, 32'h0, 3'b000);
    add(3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 24'h00B000, 32'h0, 3'b100);
    for (int i = 0; i < 4; i++) add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 24'h0, 32'h0, 3'b000);
    // All requesting with req 0 asking for a locked burst.
`ifdef PVR_ARB_LOCK_EN
    for (int i = 0; i < 8; i++) begin
      add(3'b111, 3'b000, 3'b001, 1'b0, 1'b0, 24'h00C000 + 24'(i * 16), 32'h0, 3'b001);
    end
    add(3'b111, 3'b000, 3'b001, 1'b0, 1'b0, 24'h00D000, 32'h0, 3'b010);
`else
    for (int i = 0; i < 9; i++) begin
      add(3'b111, 3'b000, 3'b001, 1'b0, 1'b0, 24'h00C000 + 24'(i * 16), 32'h0,
          3'b001 << (i % 3));
    end
`endif
    for (int i = 0; i < 5; i++) add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 24'h0, 32'h0, 3'b000);

    @(posedge clock);
    #1;
    foreach (vecs[n]) begin
      v = vecs[n];
      din = 32'h5A000000 + 32'(cyc);
      reset = v.rst; req = v.req; req_wr = v.wr; lock = v.lock; vram_busy = v.busy;
      vram_din = din;
      for (int i = 0; i < N; i++) begin
        req_addr[i*AW +: AW]  = v.a + (24'(i) << 20);
        req_wdata[i*DW +: DW] = v.d + 32'(i);
      end

      @(negedge clock);
      chk("ack_l1", 64'(ack1), 64'(v.exp_ack));
      chk("ack_l3", 64'(ack3), 64'(v.exp_ack));
      if (sb_st.size() > 0) begin
        chk("vram_port", 64'({rd1, wr1, addr1, wdata1}), 64'(sb_st.pop_front()));
      end
      if (armed) begin
        erv = 3'b000;
        if (rdq1.size() > 0 && rdq1[0].due == cyc) begin
          e = rdq1.pop_front();
          erv = 3'b001 << e.idx;
        end
        chk_rd("l1", rvalid1, rdata1, erv, din);
        erv = 3'b000;
        if (rdq3.size() > 0 && rdq3[0].due == cyc) begin
          e = rdq3.pop_front();
          erv = 3'b001 << e.idx;
        end
        chk_rd("l3", rvalid3, rdata3, erv, din);
      end

      // Scoreboard expectations for what this cycle's edge produces.
      if (v.rst) begin
        armed = 1'b1;
        last_a = '0;
        last_d = '0;
        rdq1.delete();
        rdq3.delete();
        sb_st.push_back(58'(0));
      end else if (v.exp_ack != 3'b000) begin
        w = 0;
        for (int i = 0; i < N; i++) if (v.exp_ack[i]) w = i;
        last_a = v.a + (24'(w) << 20);
        last_d = v.d + 32'(w);
        sb_st.push_back({~v.wr[w], v.wr[w], last_a, last_d});
        if (!v.wr[w]) begin
          e.idx = w;
          e.due = cyc + 2;
          rdq1.push_back(e);
          e.due = cyc + 4;
          rdq3.push_back(e);
        end
      end else begin
        sb_st.push_back({1'b0, 1'b0, last_a, last_d});
      end

      @(posedge clock);
      #1;
      cyc++;
    end

    checks++;
    if (rdq1.size() != 0 || rdq3.size() != 0) begin
      failures++;
      $display("FAIL drain pending_l1=%0d pending_l3=%0d expected=0", rdq1.size(), rdq3.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
